alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage.sv | 215 +++++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// alu_exec_stage -- two-stage ALU execute slice with valid/ready handshaking.
//
//   E1 latches an operand bundle, the ALU evaluates it combinationally and
//   E2 latches the result. The architectural NZVC register is updated when
//   a bundle moves from E1 to E2.
//
// Optional feature macro: ALU_COND_EN
//   defined   -> adds the cond input and the cond_pass output. cond_pass
//                evaluates an ARM condition code against the current flags.
//   undefined -> no condition ports and no condition logic.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   in_valid     upstream bundle valid
//   in_ready     stage can accept a bundle this cycle
//   in_a, in_b   operands
//   in_cntrl     000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor
//   in_setflags  bundle writes the architectural flags
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   out_result   registered ALU result
//   out_nzvc     registered per-op flags {N, Z, V, C}
//   flags        architectural NZVC register
//   cond         condition code (ALU_COND_EN only)
//   cond_pass    cond satisfied by flags (ALU_COND_EN only)

// Combinational ALU core. Unknown op codes produce zero and clear 'legal'.
module alu_exec_alu #(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        cntrl,
    output logic [DATA_W-1:0] result,
    output logic              v,
    output logic              c,
    output logic              legal,
    output logic              arith
);
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // A + ~B + 1: the carry out is set exactly when no borrow occurs (A >= B).
    assign diff = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};

    always_comb begin
        result = '0;
        v      = 1'b0;
        c      = 1'b0;
        legal  = 1'b1;
        arith  = 1'b0;
        case (cntrl)
            3'b000: result = b;
            3'b010: begin
                result = sum[DATA_W-1:0];
                c      = sum[DATA_W];
                // Two's-complement overflow: like-signed operands, result sign differs.
                v      = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
                arith  = 1'b1;
            end
            3'b011: begin
                result = diff[DATA_W-1:0];
                c      = diff[DATA_W];
                v      = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
                arith  = 1'b1;
            end
            3'b100: result = a & b;
            3'b101: result = a | b;
            3'b110: result = a ^ b;
            default: legal = 1'b0;
        endcase
    end
endmodule

module alu_exec_stage #(
    parameter int         DATA_W    = 64,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [2:0]        in_cntrl,
    input  logic              in_setflags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [3:0]        out_nzvc,
    output logic [3:0]        flags
`ifdef ALU_COND_EN
    ,
    input  logic [3:0]        cond,
    output logic              cond_pass
`endif
);
    logic [DATA_W-1:0] a_p1;
    logic [DATA_W-1:0] b_p1;
    logic [2:0]        cntrl_p1;
    logic              setflags_p1;
    logic              vld_p1;

    logic [DATA_W-1:0] result_p2;
    logic [3:0]        nzvc_p2;
    logic              vld_p2;

    logic [DATA_W-1:0] alu_result;
    logic              alu_v;
    logic              alu_c;
    logic              alu_legal;
    logic              alu_arith;
    logic              alu_n;
    logic              alu_z;

    logic              accept;
    logic              advance;

    assign advance  = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready = !vld_p1 || advance;
    assign accept   = in_valid && in_ready;

    // ---- E1: operand latch ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (advance) begin
            vld_p1 <= 1'b0;
        end
    end

    // Operand data carries no reset; it is qualified by vld_p1.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1        <= in_a;
            b_p1        <= in_b;
            cntrl_p1    <= in_cntrl;
            setflags_p1 <= in_setflags;
        end
    end

    alu_exec_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a_p1),
        .b      (b_p1),
        .cntrl  (cntrl_p1),
        .result (alu_result),
        .v      (alu_v),
        .c      (alu_c),
        .legal  (alu_legal),
        .arith  (alu_arith)
    );

    assign alu_n = alu_result[DATA_W-1];
    assign alu_z = (alu_result == '0);

    // ---- E2: result latch and architectural flags ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            nzvc_p2   <= 4'b0000;
            flags     <= FLAGS_RST;
        end else begin
            if (advance) begin
                vld_p2    <= 1'b1;
                result_p2 <= alu_result;
                nzvc_p2   <= {alu_n, alu_z, alu_v, alu_c};
                // Logic/pass ops only refresh N and Z; illegal ops never touch flags.
                if (setflags_p1 && alu_legal) begin
                    if (alu_arith) begin
                        flags <= {alu_n, alu_z, alu_v, alu_c};
                    end else begin
                        flags <= {alu_n, alu_z, flags[1:0]};
                    end
                end
            end else if (out_ready) begin
                vld_p2 <= 1'b0;
            end
        end
    end

    assign out_valid  = vld_p2;
    assign out_result = result_p2;
    assign out_nzvc   = nzvc_p2;

`ifdef ALU_COND_EN
    function automatic logic cond_check(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, v, c;
        {n, z, v, c} = f;
        case (cc)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return c;
            4'h3:    return !c;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return c && !z;
            4'h9:    return !c || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    assign cond_pass = cond_check(cond, flags);
`endif
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage -- directed self-checking bench for alu_exec_stage.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_alu_exec_stage;
    localparam logic [3:0] FR = 4'b0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic [2:0]  in_cntrl = 3'b000;
    logic        in_setflags = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;
    logic [3:0]  out_nzvc;
    logic [3:0]  flags;
`ifdef ALU_COND_EN
    logic [3:0]  cond = 4'h0;
    logic        cond_pass;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.DATA_W(64), .FLAGS_RST(FR)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_cntrl    (in_cntrl),
        .in_setflags (in_setflags),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_nzvc    (out_nzvc),
        .flags       (flags)
`ifdef ALU_COND_EN
        ,
        .cond        (cond),
        .cond_pass   (cond_pass)
`endif
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bundle through an otherwise idle pipe with out_ready held high.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [2:0] op, input logic sf,
                          input logic [63:0] exp_res, input logic [3:0] exp_nzvc,
                          input logic [3:0] exp_flags);
        in_a = a; in_b = b; in_cntrl = op; in_setflags = sf; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_lat"}, 64'(out_valid), 64'd0);
        tick();
        check({tag, "_vld"}, 64'(out_valid), 64'd1);
        check({tag, "_res"}, out_result, exp_res);
        check({tag, "_nzvc"}, 64'(out_nzvc), 64'(exp_nzvc));
        check({tag, "_flags"}, 64'(flags), 64'(exp_flags));
        tick();
        check({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] vals [3];
        int          acc;
        logic        took;
        vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;

        // Reset state
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_nzvc", 64'(out_nzvc), 64'd0);
        check("rst_flags", 64'(flags), 64'(FR));
        check("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed operations
        run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1,
               64'h8000_0000_0000_0000, 4'b1010, 4'b1010);
        run_op("sub_eq", 64'd1, 64'd1, 3'b011, 1'b1, 64'd0, 4'b0101, 4'b0101);
        run_op("xor_hold", 64'd1, 64'd0, 3'b110, 1'b1, 64'd1, 4'b0000, 4'b0001);
        run_op("sub_borrow", 64'd0, 64'd1, 3'b011, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 4'b1000);
        run_op("add_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1, 64'd0, 4'b0101, 4'b0101);
        run_op("and_nosf", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b100, 1'b0,
               64'hF000_F000_F000_F000, 4'b1000, 4'b0101);
        run_op("or_sf", 64'h8000_0000_0000_0000, 64'd1, 3'b101, 1'b1,
               64'h8000_0000_0000_0001, 4'b1000, 4'b1001);
        run_op("pass_b", 64'd5, 64'd0, 3'b000, 1'b1, 64'd0, 4'b0100, 4'b0101);
        run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 3'b011, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 4'b0011);
        run_op("ill_111", 64'd5, 64'd3, 3'b111, 1'b1, 64'd0, 4'b0100, 4'b0011);
        run_op("ill_001", 64'd9, 64'd4, 3'b001, 1'b1, 64'd0, 4'b0100, 4'b0011);

        // Backpressure: three bundles offered while downstream stalls
        out_ready = 1'b0;
        in_a = '0; in_cntrl = 3'b000; in_setflags = 1'b0;
        in_b = vals[0]; in_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            took = in_ready;
            tick();
            if (took) begin
                acc++;
                if (acc < 3) in_b = vals[acc];
            end
            if (c == 2) check("bp_res_c2", out_result, 64'h11);
        end
        check("bp_accepted", 64'(acc), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_res_c4", out_result, 64'h11);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_out2_vld", 64'(out_valid), 64'd1);
        check("bp_out2", out_result, 64'h22);
        tick();
        check("bp_out3_vld", 64'(out_valid), 64'd1);
        check("bp_out3", out_result, 64'h33);
        tick();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Reset with both stages occupied
        out_ready = 1'b0;
        in_a = 64'h7FFF_FFFF_FFFF_FFFF; in_b = 64'd1; in_cntrl = 3'b010; in_setflags = 1'b1;
        in_valid = 1'b1;
        tick();
        in_a = 64'd2; in_b = 64'd3;
        tick();
        in_valid = 1'b0;
        check("full_flags", 64'(flags), 64'b1010);
        check("full_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_flags", 64'(flags), 64'(FR));
        check("arst_result", out_result, 64'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("arst_no_emit", 64'(out_valid), 64'd0);
        end

`ifdef ALU_COND_EN
        // Build flags = 0110: add overflow gives 1010, then pass of zero sets Z, holds V,C
        run_op("c_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1,
               64'h8000_0000_0000_0000, 4'b1010, 4'b1010);
        run_op("c_pass", 64'd0, 64'd0, 3'b000, 1'b1, 64'd0, 4'b0100, 4'b0110);
        cond = 4'h0; #1; check("cond_eq", 64'(cond_pass), 64'd1);
        cond = 4'h1; #1; check("cond_ne", 64'(cond_pass), 64'd0);
        cond = 4'hA; #1; check("cond_ge", 64'(cond_pass), 64'd0);
        cond = 4'hD; #1; check("cond_le", 64'(cond_pass), 64'd1);
        cond = 4'hE; #1; check("cond_al", 64'(cond_pass), 64'd1);
        cond = 4'h6; #1; check("cond_vs", 64'(cond_pass), 64'd1);
        cond = 4'h8; #1; check("cond_hi", 64'(cond_pass), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
